// File: rtl/exec_unit_if.sv
// exec_unit_if: bundle between decode / register file and the execute stage.
//
// Handshake: an op transfers on a rising clock edge where InValid && InReady.
// The master holds Op/OperandA/OperandB/DestAddr stable while InValid is high
// and InReady is low. Nothing is queued, so an op offered while InReady is low
// simply waits. InReady never depends on InValid.
//
// Signals
//   InValid   master->slave  op presented this cycle
//   InReady   slave->master  unit can accept an op this cycle
//   Op        master->slave  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHL,6 SHR,7 MUL
//   OperandA  master->slave  first operand
//   OperandB  master->slave  second operand / shift amount
//   DestAddr  master->slave  destination register index
//   WriteEn   slave->master  one-cycle register file write strobe
//   Waddr     slave->master  register file write address
//   DataIn    slave->master  register file write data
//   Carry     slave->master  carry/borrow/overflow of last written result
//   Zero      slave->master  last written result == 0
//   Busy      slave->master  iterative op in progress
//   State     slave->master  debug view of the control FSM state
interface exec_unit_if #(
   parameter int W = 8,
   parameter int A = 4
);
   logic          InValid;
   logic          InReady;
   logic [2:0]    Op;
   logic [W-1:0]  OperandA;
   logic [W-1:0]  OperandB;
   logic [A-1:0]  DestAddr;
   logic          WriteEn;
   logic [A-1:0]  Waddr;
   logic [W-1:0]  DataIn;
   logic          Carry;
   logic          Zero;
   logic          Busy;
   logic [1:0]    State;

   modport master (
      output InValid, Op, OperandA, OperandB, DestAddr,
      input  InReady, WriteEn, Waddr, DataIn, Carry, Zero, Busy, State
   );

   modport slave (
      input  InValid, Op, OperandA, OperandB, DestAddr,
      output InReady, WriteEn, Waddr, DataIn, Carry, Zero, Busy, State
   );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: execute stage behind the register file.
// Accepts one op per handshake, computes it in one cycle (ADD..XOR, zero-length
// shifts) or iteratively (SHL/SHR one bit per cycle, MUL shift-add over W
// cycles) and writes the result back through WriteEn/Waddr/DataIn together
// with Carry/Zero flags that hold between writes.
//
// Ports
//   Clk    clock, all state updates on posedge
//   Reset  synchronous active-high reset
//   bus    exec_unit_if slave modport (handshake, operands, write port, flags)
module exec_unit #(
   parameter int W = 8,
   parameter int A = 4
) (
   input  logic         Clk,
   input  logic         Reset,
   exec_unit_if.slave   bus
);

   localparam int CW = $clog2(W + 1);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      MUL   = 2'd2,
      WB    = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] count;
   // MUL: {partial high half, remaining multiplier bits}; SHIFT: value in low half
   logic [2*W-1:0] prod;
   logic [W-1:0]  mcand;
   logic          shl;

   logic          accept;
   logic [W:0]    sum;
   logic [W:0]    diff;
   logic [W-1:0]  alu_res;
   logic          alu_c;
   logic [W-1:0]  shift_val;
   logic          shift_out;
   logic [W:0]    mul_sum;
   logic [2*W-1:0] mul_next;

   assign bus.InReady = (state == IDLE) && !Reset;
   assign bus.Busy    = (state != IDLE);
   assign bus.State   = state;
   assign accept      = bus.InValid && bus.InReady;

   // Single-cycle results, also used for shifts by zero (result = OperandA).
   always_comb begin
      sum     = {1'b0, bus.OperandA} + {1'b0, bus.OperandB};
      diff    = {1'b0, bus.OperandA} - {1'b0, bus.OperandB};
      alu_res = bus.OperandA;
      alu_c   = 1'b0;
      case (bus.Op)
         OP_ADD: begin
            alu_res = sum[W-1:0];
            alu_c   = sum[W];
         end
         OP_SUB: begin
            alu_res = diff[W-1:0];
            alu_c   = ~diff[W];   // no borrow means A >= B
         end
         OP_AND:  alu_res = bus.OperandA & bus.OperandB;
         OP_OR:   alu_res = bus.OperandA | bus.OperandB;
         OP_XOR:  alu_res = bus.OperandA ^ bus.OperandB;
         default: alu_res = bus.OperandA;
      endcase
   end

   // One-bit shift step with zero fill; shift_out is the bit leaving the word.
   always_comb begin
      if (shl) begin
         shift_val = {prod[W-2:0], 1'b0};
         shift_out = prod[W-1];
      end else begin
         shift_val = {1'b0, prod[W-1:1]};
         shift_out = prod[0];
      end
   end

   // One shift-add multiply step: add multiplicand to the high half when the
   // current multiplier LSB is set, then shift the whole product right by one.
   always_comb begin
      mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : {(W+1){1'b0}});
      mul_next = {mul_sum, prod[W-1:1]};
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         count       <= '0;
         prod        <= '0;
         mcand       <= '0;
         shl         <= 1'b0;
         bus.WriteEn <= 1'b0;
         bus.Waddr   <= '0;
         bus.DataIn  <= '0;
         bus.Carry   <= 1'b0;
         bus.Zero    <= 1'b0;
      end else begin
         bus.WriteEn <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  bus.Waddr <= bus.DestAddr;
                  if (bus.Op == OP_MUL) begin
                     state <= MUL;
                     count <= CW'(W);
                     prod  <= {{W{1'b0}}, bus.OperandB};
                     mcand <= bus.OperandA;
                  end else if ((bus.Op == OP_SHL || bus.Op == OP_SHR) &&
                               bus.OperandB[2:0] != 3'd0) begin
                     state <= SHIFT;
                     count <= CW'(bus.OperandB[2:0]);
                     prod  <= {{W{1'b0}}, bus.OperandA};
                     shl   <= (bus.Op == OP_SHL);
                  end else begin
                     bus.WriteEn <= 1'b1;
                     bus.DataIn  <= alu_res;
                     bus.Carry   <= alu_c;
                     bus.Zero    <= (alu_res == '0);
                  end
               end
            end
            SHIFT: begin
               prod[W-1:0] <= shift_val;
               count       <= count - 1'b1;
               if (count == CW'(1)) begin
                  // Last step: the write strobe is held through the WB cycle.
                  state       <= WB;
                  bus.WriteEn <= 1'b1;
                  bus.DataIn  <= shift_val;
                  bus.Carry   <= shift_out;
                  bus.Zero    <= (shift_val == '0);
               end
            end
            MUL: begin
               prod  <= mul_next;
               count <= count - 1'b1;
               if (count == CW'(1)) begin
                  state       <= WB;
                  bus.WriteEn <= 1'b1;
                  bus.DataIn  <= mul_next[W-1:0];
                  bus.Carry   <= (mul_next[2*W-1:W] != '0);
                  bus.Zero    <= (mul_next[W-1:0] == '0);
               end
            end
            WB: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
